operand_fetch: RTL

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch_pkg.sv | 16 +
 rtl/operand_fetch_bypass.sv | 70 +++++++
 rtl/operand_fetch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared widths and FSM state encoding for the operand fetch stage.
package operand_fetch_pkg;

  localparam int unsigned OF_DATA_WIDTH        = 64;
  localparam int unsigned OF_REG_INDEX_BITS    = 5;
  localparam int unsigned OF_THREAD_INDEX_BITS = 3;
  localparam int unsigned OF_ADDR_W            = OF_REG_INDEX_BITS + OF_THREAD_INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD_A = 2'd1,
    ST_RD_B = 2'd2,
    ST_HOLD = 2'd3
  } of_state_e;

endpackage

// File: rtl/operand_fetch_bypass.sv
// One operand register with zero-index handling and writeback forwarding
// across the issue, capture and hold windows.
module operand_bypass #(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned REG_INDEX_BITS = 5,
  parameter int unsigned ADDR_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_i,
  input  logic                  capture_i,
  input  logic                  track_i,
  input  logic                  used_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0] rf_rdata_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_W-1:0]     wb_waddr_i,
  input  logic [DATA_WIDTH-1:0] wb_wdata_i,
  output logic [DATA_WIDTH-1:0] op_o
);

  logic                  is_zero_c;
  logic                  wb_hit_c;
  logic                  byp_q, byp_d;
  logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
  logic [DATA_WIDTH-1:0] op_q, op_d;

  assign is_zero_c = !used_i || (addr_i[REG_INDEX_BITS-1:0] == '0);
  assign wb_hit_c  = wb_we_i && (wb_waddr_i[REG_INDEX_BITS-1:0] != '0) && (wb_waddr_i == addr_i);

  // A write in the issue cycle lands too late for the RF read, so it is held for capture.
  always_comb begin
    byp_d      = byp_q;
    byp_data_d = byp_data_q;
    op_d       = op_q;
    if (issue_i) begin
      byp_d      = wb_hit_c;
      byp_data_d = wb_wdata_i;
    end
    if (capture_i) begin
      byp_d = 1'b0;
      if (is_zero_c) begin
        op_d = '0;
      end else if (wb_hit_c) begin
        op_d = wb_wdata_i;
      end else if (byp_q) begin
        op_d = byp_data_q;
      end else begin
        op_d = rf_rdata_i;
      end
    end else if (track_i && !is_zero_c && wb_hit_c) begin
      op_d = wb_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      op_q       <= '0;
    end else begin
      byp_q      <= byp_d;
      byp_data_q <= byp_data_d;
      op_q       <= op_d;
    end
  end

  assign op_o = op_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads rs1 then rs2 from a one-cycle-latency register
// file through one shared port and holds the operands until downstream accepts.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = OF_DATA_WIDTH,
  parameter int unsigned REG_INDEX_BITS    = OF_REG_INDEX_BITS,
  parameter int unsigned THREAD_INDEX_BITS = OF_THREAD_INDEX_BITS
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [THREAD_INDEX_BITS-1:0]                in_thread,
  input  logic [REG_INDEX_BITS-1:0]                   in_rs1,
  input  logic [REG_INDEX_BITS-1:0]                   in_rs2,
  input  logic                                        in_use_rs2,
  output logic [REG_INDEX_BITS+THREAD_INDEX_BITS-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0]                       rf_rdata,
  input  logic                                        wb_we,
  input  logic [REG_INDEX_BITS+THREAD_INDEX_BITS-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0]                       wb_wdata,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [THREAD_INDEX_BITS-1:0]                out_thread,
  output logic [DATA_WIDTH-1:0]                       out_op_a,
  output logic [DATA_WIDTH-1:0]                       out_op_b
);

  localparam int unsigned ADDR_W = REG_INDEX_BITS + THREAD_INDEX_BITS;

  of_state_e                    state_q, state_d;
  logic [THREAD_INDEX_BITS-1:0] thread_q, thread_d;
  logic [REG_INDEX_BITS-1:0]    rs1_q, rs1_d;
  logic [REG_INDEX_BITS-1:0]    rs2_q, rs2_d;
  logic                         use_rs2_q, use_rs2_d;
  logic                         out_valid_q, out_valid_d;
  logic                         accept_c;
  logic [ADDR_W-1:0]            addr_a_c, addr_b_c;
  logic                         issue_b_c, cap_a_c, cap_b_c, track_a_c, track_b_c;

  // Next-state, handshake and shared read-port address.
  always_comb begin
    state_d     = state_q;
    thread_d    = thread_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    use_rs2_d   = use_rs2_q;
    in_ready    = rst_n && (state_q == ST_IDLE);
    accept_c    = in_valid && in_ready;
    rf_raddr    = {thread_q, rs1_q};
    case (state_q)
      ST_IDLE: begin
        rf_raddr = {in_thread, in_rs1};
        if (accept_c) begin
          thread_d  = in_thread;
          rs1_d     = in_rs1;
          rs2_d     = in_rs2;
          use_rs2_d = in_use_rs2;
          state_d   = ST_RD_A;
        end
      end
      ST_RD_A: begin
        rf_raddr = {thread_q, rs2_q};
        state_d  = use_rs2_q ? ST_RD_B : ST_HOLD;
      end
      ST_RD_B: state_d = ST_HOLD;
      ST_HOLD: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      thread_q    <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      use_rs2_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      thread_q    <= thread_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      use_rs2_q   <= use_rs2_d;
      out_valid_q <= out_valid_d;
    end
  end

  // rs1 is issued in IDLE from the live inputs; rs2 is issued in RD_A from the latched ones.
  assign addr_a_c  = (state_q == ST_IDLE) ? {in_thread, in_rs1} : {thread_q, rs1_q};
  assign addr_b_c  = {thread_q, rs2_q};
  assign cap_a_c   = (state_q == ST_RD_A);
  assign track_a_c = (state_q == ST_RD_B) || (state_q == ST_HOLD);
  assign issue_b_c = (state_q == ST_RD_A) && use_rs2_q;
  assign cap_b_c   = (state_q == ST_RD_B) || ((state_q == ST_RD_A) && !use_rs2_q);
  assign track_b_c = (state_q == ST_HOLD);

  operand_bypass #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_INDEX_BITS(REG_INDEX_BITS),
    .ADDR_W        (ADDR_W)
  ) u_byp_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_i   (accept_c),
    .capture_i (cap_a_c),
    .track_i   (track_a_c),
    .used_i    (1'b1),
    .addr_i    (addr_a_c),
    .rf_rdata_i(rf_rdata),
    .wb_we_i   (wb_we),
    .wb_waddr_i(wb_waddr),
    .wb_wdata_i(wb_wdata),
    .op_o      (out_op_a)
  );

  operand_bypass #(
    .DATA_WIDTH    (DATA_WIDTH),
    .REG_INDEX_BITS(REG_INDEX_BITS),
    .ADDR_W        (ADDR_W)
  ) u_byp_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue_i   (issue_b_c),
    .capture_i (cap_b_c),
    .track_i   (track_b_c),
    .used_i    (use_rs2_q),
    .addr_i    (addr_b_c),
    .rf_rdata_i(rf_rdata),
    .wb_we_i   (wb_we),
    .wb_waddr_i(wb_waddr),
    .wb_wdata_i(wb_wdata),
    .op_o      (out_op_b)
  );

  assign out_valid  = out_valid_q;
  assign out_thread = thread_q;

endmodule
